// File: rtl/siso_shift_ctrl_if.sv
// Parallel/serial handshake bundle for the SISO shift sequencer.
// The master drives start/din/abort/sin; the slave (sequencer) drives the status and data outputs.
interface siso_shift_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] din;
    logic             abort;
    logic             sin;
    logic             sout;
    logic             shift_en;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dout;

    modport master (
        output start, din, abort, sin,
        input  sout, shift_en, ready, busy, done, dout
    );

    modport slave (
        input  start, din, abort, sin,
        output sout, shift_en, ready, busy, done, dout
    );
endinterface

// File: rtl/siso_shift_ctrl.sv
// WIDTH-bit serial-in/serial-out shift sequencer: loads a word, shifts it out while
// capturing sin, and publishes the captured word with a one-cycle done pulse.
//
// state    | meaning
// ST_IDLE  | ready for start; shift register idle
// ST_SHIFT | WIDTH shift cycles, sout valid, sin sampled each edge
// ST_DONE  | one-cycle done pulse, dout just updated
module siso_shift_ctrl #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    siso_shift_ctrl_if.slave bus
);
    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] shifted;
    logic             out_bit;

    // The output end and the vacated end swap with bit order.
    generate
        if (LSB_FIRST) begin : g_lsb
            assign shifted = {bus.sin, shreg_q[WIDTH-1:1]};
            assign out_bit = shreg_q[0];
        end else begin : g_msb
            assign shifted = {shreg_q[WIDTH-2:0], bus.sin};
            assign out_bit = shreg_q[WIDTH-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            dout_q  <= dout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        dout_d  = dout_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    shreg_d = bus.din;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Abort beats completion, so dout is never touched on an aborted word.
                if (bus.abort) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    shreg_d = shifted;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        dout_d  = shifted;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.ready    = (state_q == ST_IDLE);
    assign bus.shift_en = (state_q == ST_SHIFT);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.busy     = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    assign bus.sout     = (state_q == ST_SHIFT) && out_bit;
    assign bus.dout     = dout_q;
endmodule

// File: tb/tb_siso_shift_ctrl.sv
// Bench for siso_shift_ctrl: an MSB-first loopback instance and an LSB-first instance
// with driven sin; expected sout bits and dout words are queued and checked by monitors.
module tb_siso_shift_ctrl;
    logic clk;
    logic rst_n;

    siso_shift_ctrl_if #(.WIDTH(8)) if0 ();
    siso_shift_ctrl_if #(.WIDTH(8)) if1 ();

    siso_shift_ctrl #(.WIDTH(8), .LSB_FIRST(1'b0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    siso_shift_ctrl #(.WIDTH(8), .LSB_FIRST(1'b1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    assign if0.sin = if0.sout;

    int n_chk  = 0;
    int n_fail = 0;
    int done0_cnt = 0;
    int done1_cnt = 0;

    logic       q_sout0[$];
    logic [7:0] q_dout0[$];
    logic       q_sout1[$];
    logic [7:0] q_dout1[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_msb0(input logic [7:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) q_sout0.push_back(w[7-i]);
    endtask

    task automatic go0(input logic [7:0] w);
        if0.din   = w;
        if0.start = 1'b1;
        cyc(1);
        if0.start = 1'b0;
    endtask

    // Scoreboard monitors, sampling on the falling edge away from state updates.
    always @(negedge clk) begin
        if (rst_n) begin
            if (if0.shift_en) begin
                if (q_sout0.size() == 0) check("sout0_unexpected", 32'(if0.sout), 32'hx);
                else check("sout0", 32'(if0.sout), 32'(q_sout0.pop_front()));
            end
            if (if0.done) begin
                done0_cnt++;
                if (q_dout0.size() == 0) check("dout0_unexpected", 32'(if0.dout), 32'hx);
                else check("dout0", 32'(if0.dout), 32'(q_dout0.pop_front()));
            end
            if (if1.shift_en) begin
                if (q_sout1.size() == 0) check("sout1_unexpected", 32'(if1.sout), 32'hx);
                else check("sout1", 32'(if1.sout), 32'(q_sout1.pop_front()));
            end
            if (if1.done) begin
                done1_cnt++;
                if (q_dout1.size() == 0) check("dout1_unexpected", 32'(if1.dout), 32'hx);
                else check("dout1", 32'(if1.dout), 32'(q_dout1.pop_front()));
            end
        end
    end

    initial begin
        logic [7:0] sin_pat;
        logic [7:0] lsb_sout;
        int         d_before;

        rst_n     = 1'b0;
        if0.start = 1'b0;
        if0.din   = 8'h00;
        if0.abort = 1'b0;
        if1.start = 1'b0;
        if1.din   = 8'h00;
        if1.abort = 1'b0;
        if1.sin   = 1'b0;

        // Reset held while clock and start toggle
        repeat (3) begin
            @(posedge clk);
            #1;
            if0.start = ~if0.start;
            if0.din   = 8'hA5;
            if1.start = ~if1.start;
        end
        check("rst_ready",    32'(if0.ready),    32'd1);
        check("rst_busy",     32'(if0.busy),     32'd0);
        check("rst_done",     32'(if0.done),     32'd0);
        check("rst_shift_en", 32'(if0.shift_en), 32'd0);
        check("rst_sout",     32'(if0.sout),     32'd0);
        check("rst_dout",     32'(if0.dout),     32'h00);
        check("rst_ready1",   32'(if1.ready),    32'd1);
        if0.start = 1'b0;
        if1.start = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(1);

        // MSB-first loopback, A5, with cycle-accurate timing
        push_msb0(8'hA5, 8);
        q_dout0.push_back(8'hA5);
        go0(8'hA5);
        check("a5_busy_c1", 32'(if0.busy), 32'd1);
        cyc(8);
        check("a5_done_c9", 32'(if0.done), 32'd1);
        check("a5_dout_c9", 32'(if0.dout), 32'hA5);
        cyc(1);
        check("a5_ready_c10", 32'(if0.ready), 32'd1);
        check("a5_done_c10",  32'(if0.done),  32'd0);
        check("a5_busy_c10",  32'(if0.busy),  32'd0);
        cyc(2);

        // LSB-first capture with driven sin
        sin_pat  = 8'b0000_0011;
        lsb_sout = 8'h3C;
        for (int i = 0; i < 8; i++) q_sout1.push_back(lsb_sout[i]);
        q_dout1.push_back(8'h03);
        if1.din   = 8'h3C;
        if1.start = 1'b1;
        cyc(1);
        if1.start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if1.sin = sin_pat[k];
            cyc(1);
        end
        if1.sin = 1'b0;
        check("lsb_done_c9", 32'(if1.done), 32'd1);
        check("lsb_dout",    32'(if1.dout), 32'h03);
        cyc(1);
        check("lsb_ready", 32'(if1.ready), 32'd1);
        cyc(2);

        // Start while busy is ignored
        d_before = done0_cnt;
        push_msb0(8'h12, 8);
        q_dout0.push_back(8'h12);
        go0(8'h12);
        cyc(3);
        if0.din   = 8'hFF;
        if0.start = 1'b1;
        cyc(1);
        if0.start = 1'b0;
        cyc(5);
        check("busy_start_ready", 32'(if0.ready), 32'd1);
        check("busy_start_dout",  32'(if0.dout),  32'h12);
        cyc(10);
        check("busy_start_one_done", 32'(done0_cnt - d_before), 32'd1);
        check("busy_start_idle",     32'(if0.shift_en),         32'd0);

        // Abort mid-shift after an earlier completed 5A
        push_msb0(8'h5A, 8);
        q_dout0.push_back(8'h5A);
        go0(8'h5A);
        cyc(10);
        d_before = done0_cnt;
        push_msb0(8'hC3, 5);
        go0(8'hC3);
        cyc(4);
        if0.abort = 1'b1;
        cyc(1);
        if0.abort = 1'b0;
        check("abort_shift_en", 32'(if0.shift_en), 32'd0);
        check("abort_ready",    32'(if0.ready),    32'd1);
        check("abort_dout",     32'(if0.dout),     32'h5A);
        push_msb0(8'h69, 8);
        q_dout0.push_back(8'h69);
        go0(8'h69);
        check("abort_restart", 32'(if0.shift_en), 32'd1);
        check("abort_no_done", 32'(done0_cnt - d_before), 32'd0);
        cyc(10);

        // Asynchronous reset in shift cycle 3
        push_msb0(8'h77, 2);
        go0(8'h77);
        cyc(2);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_shift_en", 32'(if0.shift_en), 32'd0);
        check("arst_ready",    32'(if0.ready),    32'd1);
        check("arst_busy",     32'(if0.busy),     32'd0);
        check("arst_sout",     32'(if0.sout),     32'd0);
        check("arst_dout",     32'(if0.dout),     32'h00);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        push_msb0(8'h81, 8);
        q_dout0.push_back(8'h81);
        go0(8'h81);
        cyc(8);
        check("arst_81_done", 32'(if0.done), 32'd1);
        check("arst_81_dout", 32'(if0.dout), 32'h81);
        cyc(4);

        check("q_sout0_empty", 32'(q_sout0.size()), 32'd0);
        check("q_dout0_empty", 32'(q_dout0.size()), 32'd0);
        check("q_sout1_empty", 32'(q_sout1.size()), 32'd0);
        check("q_dout1_empty", 32'(q_dout1.size()), 32'd0);
        check("done0_total",   32'(done0_cnt),      32'd5);
        check("done1_total",   32'(done1_cnt),      32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/siso_shift_ctrl.md
# siso_shift_ctrl

Sequencer for a WIDTH-bit serial-in/serial-out shift register built from posedge D flip-flops. It accepts a parallel word on a start strobe and shifts it out on `sout` over exactly WIDTH clocks. During the same clocks it captures WIDTH bits from `sin` and presents them as a parallel word with a one-cycle `done` pulse. It sits between a parallel producer/consumer and a serial link, or a SISO chain, and owns the shift register, the bit counter and the control FSM.

## Interface
- WIDTH, 8: word length in bits (≥2).
- LSB_FIRST, 0: 0 = MSB shifted out and captured first; 1 = LSB first.

- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a transfer; honoured only when `ready`=1.
- din  in  WIDTH  word to transmit, sampled on the edge that accepts `start`.
- abort  in  1  cancel an active transfer.
- sin  in  1  serial input, sampled on each rising edge that ends a SHIFT cycle.
- sout  out  1  serial output; valid only while `shift_en`=1, otherwise 0.
- shift_en  out  1  high during each of the WIDTH shift cycles.
- ready  out  1  high in IDLE.
- busy  out  1  high in SHIFT or DONE.
- done  out  1  one-cycle pulse when `dout` is updated.
- dout  out  WIDTH  last completed captured word, held until the next completion.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- Internal registers: WIDTH-bit `shreg` and a counter wide enough for 0..WIDTH-1.
- **IDLE:** `ready`=1. If `start`=1 at an edge:
  - `shreg` ← `din`.
  - counter ← 0.
  - next state is SHIFT.
  - If `start` and `abort` are both high, `start` wins and `abort` is ignored in IDLE.
- **SHIFT:** `shift_en`=1. `sout` = `shreg[WIDTH-1]` (MSB-first) or `shreg[0]` (LSB-first). At each edge:
  - `shreg` shifts one place toward the output end.
  - `sin` enters at the vacated end (bit 0 for MSB-first, bit WIDTH-1 for LSB-first).
  - The counter increments.
  - At the edge where counter = WIDTH-1, `dout` ← the shifted result and the next state is DONE.
- **Capture order:** the first-sampled `sin` bit lands in `dout[WIDTH-1]` (MSB-first) or `dout[0]` (LSB-first). Looping `sout` back to `sin` therefore gives `dout` = `din`.
- **abort in SHIFT:** at the edge where `abort`=1, the next state is IDLE.
  - `dout` is unchanged and no `done` pulse occurs.
  - `abort` takes priority over completion on the final shift edge.
- **DONE:** `done`=1 for exactly one cycle. The next state is always IDLE. `start` and `abort` are ignored.
- `start` in SHIFT or DONE is ignored; it is not queued.
- **Reset:** whenever `rst_n`=0, without waiting for an edge:
  - state = IDLE, counter = 0, `shreg` = 0, `dout` = 0.
  - Outputs: `ready`=1, `busy`=0, `done`=0, `shift_en`=0, `sout`=0.
  - This applies mid-transfer; the partial word is discarded.
- `ready`, `busy`, `shift_en`, `done` and `sout` are decoded from the registered state and `shreg` only. There is no combinational path from `start`, `abort` or `sin` to any output.

## Timing
- Edge E0 accepts `start` (IDLE, `start`=1).
- Cycles 1..WIDTH (after E0 .. before E_WIDTH): `shift_en`=1. In cycle k, `sout` carries the k-th bit in transmit order.
- `sin` is sampled at E1..E_WIDTH, one bit per edge.
- Cycle WIDTH+1: `done`=1 and the new `dout` is visible.
- Cycle WIDTH+2: `ready`=1. The earliest next accept is edge E_(WIDTH+2).
- Minimum start-to-start period is WIDTH+2 cycles. Start-to-done latency is WIDTH+1 cycles.
- An abort sampled at edge Ek (1 ≤ k ≤ WIDTH) gives `ready`=1 from cycle k+1.

## Test plan
- **Reset:** hold `rst_n`=0 and toggle `clk`/`start` → `ready`=1, `busy`=0, `done`=0, `shift_en`=0, `sout`=0, `dout`=8'h00.
- **Loopback, MSB-first:** WIDTH=8, LSB_FIRST=0, `sin` tied to `sout`, start with `din`=8'hA5.
  - `sout` across the 8 `shift_en` cycles reads 1,0,1,0,0,1,0,1.
  - `done` rises 9 cycles after the accept edge with `dout`=8'hA5.
  - `ready` returns 1 cycle after `done`.
- **LSB-first capture:** LSB_FIRST=1, `din`=8'h3C, drive `sin` = 1,1,0,0,0,0,0,0.
  - `sout` reads 0,0,1,1,1,1,0,0.
  - `dout`=8'h03.
- **Start while busy:** pulse `start` with `din`=8'hFF during cycle 4 of a transfer of 8'h12 (loopback).
  - `dout`=8'h12.
  - Exactly one `done` pulse.
  - No second transfer begins.
- **Abort:** assert `abort` for one cycle at shift cycle 5 of 8'hC3 after an earlier `dout`=8'h5A.
  - `shift_en` drops the next cycle and no `done` pulse occurs.
  - `dout` stays 8'h5A.
  - A new start is accepted in the following cycle.
- **Async reset mid-shift:** drop `rst_n` between edges in cycle 3.
  - Outputs return to reset values immediately, without a clock edge.
  - After release, a fresh 8'h81 loopback transfer completes with `dout`=8'h81.
